// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI slave with synchronized bus inputs, TX holding register and byte-wide RX
// Optional error pulses (o_tx_underrun, o_frame_abort) exist only when SPI_SLAVE_ERR_EN is defined.
module spi_slave #(
    parameter int         SPI_MODE   = 0,
    parameter logic [7:0] DEFAULT_TX = 8'hFF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] i_tx_byte,
    input  logic       i_tx_dv,
    output logic       o_tx_ready,
    output logic [7:0] o_rx_byte,
    output logic       o_rx_dv,
    input  logic       i_spi_clk,
    input  logic       i_spi_cs_n,
    input  logic       i_spi_mosi,
    output logic       o_spi_miso,
    output logic       o_spi_miso_oe
`ifdef SPI_SLAVE_ERR_EN
    ,
    output logic       o_tx_underrun,
    output logic       o_frame_abort
`endif
);

    localparam logic CPOL = (SPI_MODE == 2) || (SPI_MODE == 3);
    localparam logic CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);

    typedef enum logic [1:0] {
        ST_DISARMED,
        ST_IDLE,
        ST_FRAME
    } state_t;

    state_t state_q, state_d;

    logic       sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic       cs_meta_q, cs_sync_q, cs_prev_q;
    logic       mosi_meta_q, mosi_sync_q;
    logic [1:0] fill_q;

    logic [7:0] rx_shift_q, rx_shift_d;
    logic [2:0] rx_cnt_q, rx_cnt_d;
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       rx_dv_q, rx_dv_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [2:0] tx_ptr_q, tx_ptr_d;
    logic       miso_q, miso_d;
    logic       oe_q, oe_d;

    logic       in_frame, cs_fall, cs_rise;
    logic       sclk_edge, leading_edge, trailing_edge;
    logic       sample_edge, shift_edge;
    logic       load_evt;
    logic [7:0] load_byte;

    // Synchronizers come out of reset holding idle bus levels.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_meta_q <= CPOL;
            sclk_sync_q <= CPOL;
            sclk_prev_q <= CPOL;
            cs_meta_q   <= 1'b1;
            cs_sync_q   <= 1'b1;
            cs_prev_q   <= 1'b1;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
            fill_q      <= 2'b00;
        end else begin
            sclk_meta_q <= i_spi_clk;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            cs_meta_q   <= i_spi_cs_n;
            cs_sync_q   <= cs_meta_q;
            cs_prev_q   <= cs_sync_q;
            mosi_meta_q <= i_spi_mosi;
            mosi_sync_q <= mosi_meta_q;
            fill_q      <= {fill_q[0], 1'b1};
        end
    end

    // A frame only starts from a cs_n high level seen after reset, so a
    // reset in mid-frame cannot resume the aborted transfer.
    assign cs_fall  = (state_q == ST_IDLE) && cs_prev_q && !cs_sync_q;
    assign cs_rise  = (state_q == ST_FRAME) && !cs_prev_q && cs_sync_q;
    assign in_frame = (state_q == ST_FRAME) && !cs_sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_DISARMED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_DISARMED: if (fill_q[1] && cs_sync_q) state_d = ST_IDLE;
            ST_IDLE:     if (cs_fall) state_d = ST_FRAME;
            ST_FRAME:    if (cs_rise) state_d = ST_IDLE;
            default:     state_d = ST_DISARMED;
        endcase
    end

    assign sclk_edge     = in_frame && (sclk_sync_q != sclk_prev_q);
    assign leading_edge  = sclk_edge && (sclk_sync_q != CPOL);
    assign trailing_edge = sclk_edge && (sclk_sync_q == CPOL);
    assign sample_edge   = CPHA ? trailing_edge : leading_edge;
    assign shift_edge    = CPHA ? leading_edge : trailing_edge;

    // rx_dv_q marks the cycle after the 8th sample edge.
    assign load_evt  = cs_fall || (rx_dv_q && in_frame);
    assign load_byte = hold_full_q ? hold_q : (i_tx_dv ? i_tx_byte : DEFAULT_TX);

    always_comb begin
        rx_shift_d  = rx_shift_q;
        rx_cnt_d    = rx_cnt_q;
        rx_byte_d   = rx_byte_q;
        rx_dv_d     = 1'b0;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        tx_shift_d  = tx_shift_q;
        tx_ptr_d    = tx_ptr_q;
        miso_d      = miso_q;
        oe_d        = oe_q;

        if (sample_edge) begin
            rx_shift_d = {rx_shift_q[6:0], mosi_sync_q};
            rx_cnt_d   = rx_cnt_q - 3'd1;
            if (rx_cnt_q == 3'd0) begin
                rx_byte_d = {rx_shift_q[6:0], mosi_sync_q};
                rx_dv_d   = 1'b1;
            end
        end

        if (load_evt) begin
            tx_shift_d  = load_byte;
            hold_full_d = 1'b0;
            if (!CPHA && cs_fall) begin
                miso_d   = load_byte[7];
                tx_ptr_d = 3'd6;
            end else begin
                tx_ptr_d = 3'd7;
            end
        end else begin
            if (i_tx_dv && !hold_full_q) begin
                hold_d      = i_tx_byte;
                hold_full_d = 1'b1;
            end
            if (shift_edge) begin
                miso_d   = tx_shift_q[tx_ptr_q];
                tx_ptr_d = tx_ptr_q - 3'd1;
            end
        end

        if (cs_fall) begin
            oe_d = 1'b1;
        end
        if (cs_rise) begin
            rx_cnt_d = 3'd7;
            tx_ptr_d = 3'd7;
            miso_d   = 1'b0;
            oe_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_shift_q  <= 8'h00;
            rx_cnt_q    <= 3'd7;
            rx_byte_q   <= 8'h00;
            rx_dv_q     <= 1'b0;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            tx_shift_q  <= 8'h00;
            tx_ptr_q    <= 3'd7;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
        end else begin
            rx_shift_q  <= rx_shift_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_byte_q   <= rx_byte_d;
            rx_dv_q     <= rx_dv_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_shift_q  <= tx_shift_d;
            tx_ptr_q    <= tx_ptr_d;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
        end
    end

    assign o_tx_ready    = !hold_full_q;
    assign o_rx_byte     = rx_byte_q;
    assign o_rx_dv       = rx_dv_q;
    assign o_spi_miso    = miso_q;
    assign o_spi_miso_oe = oe_q;

`ifdef SPI_SLAVE_ERR_EN
    logic underrun_q, abort_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            underrun_q <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            underrun_q <= load_evt && !hold_full_q && !i_tx_dv;
            abort_q    <= cs_rise && (rx_cnt_q != 3'd7);
        end
    end

    assign o_tx_underrun = underrun_q;
    assign o_frame_abort = abort_q;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - directed scoreboard bench for spi_slave, one instance per SPI mode
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] tx_byte;
    logic [3:0] tx_dv;
    logic [3:0] sclk;
    logic [3:0] cs_n;
    logic       mosi;
    logic [3:0] tx_ready, rx_dv, miso, oe;
    logic [7:0] rx_byte [4];
`ifdef SPI_SLAVE_ERR_EN
    logic [3:0] underrun, abort_p;
    int         ur_cnt [4];
    int         ab_cnt [4];
`endif

    int         checks = 0;
    int         errors = 0;
    int         dv_cnt [4];
    int         exp_rx [$];
    logic [7:0] exp_tx [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave #(
            .SPI_MODE  (g),
            .DEFAULT_TX(8'hFF)
        ) u_dut (
            .clk          (clk),
            .reset_n      (reset_n),
            .i_tx_byte    (tx_byte),
            .i_tx_dv      (tx_dv[g]),
            .o_tx_ready   (tx_ready[g]),
            .o_rx_byte    (rx_byte[g]),
            .o_rx_dv      (rx_dv[g]),
            .i_spi_clk    (sclk[g]),
            .i_spi_cs_n   (cs_n[g]),
            .i_spi_mosi   (mosi),
            .o_spi_miso   (miso[g]),
            .o_spi_miso_oe(oe[g])
`ifdef SPI_SLAVE_ERR_EN
            ,
            .o_tx_underrun(underrun[g]),
            .o_frame_abort(abort_p[g])
`endif
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // RX scoreboard: entries are mode*256 + byte.
    always @(negedge clk) begin
        for (int m = 0; m < 4; m++) begin
            if (rx_dv[m] === 1'b1) begin
                dv_cnt[m]++;
                if (exp_rx.size() == 0) begin
                    chk("rx_unexpected_dv", 32'(m), 32'hFFFF_FFFF);
                end else begin
                    chk("rx_byte", 32'(m * 256 + int'(rx_byte[m])), 32'(exp_rx.pop_front()));
                end
            end
`ifdef SPI_SLAVE_ERR_EN
            if (underrun[m] === 1'b1) ur_cnt[m]++;
            if (abort_p[m] === 1'b1) ab_cnt[m]++;
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic half();
        repeat (8) @(negedge clk);
    endtask

    task automatic queue_tx(input int m, input logic [7:0] b);
        @(negedge clk);
        tx_byte  = b;
        tx_dv[m] = 1'b1;
        @(negedge clk);
        tx_dv[m] = 1'b0;
    endtask

    task automatic cs_low(input int m);
        @(negedge clk);
        cs_n[m] = 1'b0;
        half();
    endtask

    task automatic cs_high(input int m);
        half();
        cs_n[m] = 1'b1;
        half();
        half();
    endtask

    task automatic xfer_bits(input int m, input logic [7:0] b, input int nbits, output logic [7:0] got);
        logic cpol, cpha;
        cpol = (m == 2) || (m == 3);
        cpha = (m == 1) || (m == 3);
        got  = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            if (!cpha) begin
                mosi = b[i];
                half();
                got[i]  = miso[m];
                sclk[m] = ~cpol;
                half();
                sclk[m] = cpol;
            end else begin
                sclk[m] = ~cpol;
                mosi    = b[i];
                half();
                got[i]  = miso[m];
                sclk[m] = cpol;
                half();
            end
        end
    endtask

    task automatic xfer_chk(input int m, input logic [7:0] b, input string tag);
        logic [7:0] got;
        exp_rx.push_back(m * 256 + int'(b));
        xfer_bits(m, b, 8, got);
        if (exp_tx.size() == 0) chk({tag, "_txq_empty"}, 32'(got), 32'hFFFF_FFFF);
        else                    chk(tag, 32'(got), 32'(exp_tx.pop_front()));
    endtask

    int         d, u, a;
    logic [7:0] junk;

    initial begin
        reset_n = 1'b0;
        tx_byte = 8'h00;
        tx_dv   = 4'h0;
        sclk    = 4'b1100;
        cs_n    = 4'hF;
        mosi    = 1'b0;
        repeat (3) @(negedge clk);
        for (int m = 0; m < 4; m++) begin
            chk("rst_tx_ready", 32'(tx_ready[m]), 32'd1);
            chk("rst_rx_dv",    32'(rx_dv[m]),    32'd0);
            chk("rst_rx_byte",  32'(rx_byte[m]),  32'd0);
            chk("rst_miso",     32'(miso[m]),     32'd0);
            chk("rst_oe",       32'(oe[m]),       32'd0);
        end
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // Mode 0: A5 out, 3C in
        queue_tx(0, 8'hA5);
        exp_tx.push_back(8'hA5);
        chk("m0_ready_after_queue", 32'(tx_ready[0]), 32'd0);
        d = dv_cnt[0];
        cs_low(0);
        chk("m0_ready_after_fall", 32'(tx_ready[0]), 32'd1);
        chk("m0_oe_in_frame", 32'(oe[0]), 32'd1);
        xfer_chk(0, 8'h3C, "m0_miso_a5");
        cs_high(0);
        chk("m0_dv_count", 32'(dv_cnt[0] - d), 32'd1);
        chk("m0_rx_byte", 32'(rx_byte[0]), 32'h3C);
        chk("m0_oe_after", 32'(oe[0]), 32'd0);
        chk("m0_miso_after", 32'(miso[0]), 32'd0);

        // Mode 3: two-byte frame, second TX byte queued mid byte 1
        queue_tx(3, 8'h11);
        exp_tx.push_back(8'h11);
        exp_tx.push_back(8'h22);
        d = dv_cnt[3];
        cs_low(3);
        fork
            xfer_chk(3, 8'h81, "m3_miso_b1");
            begin
                repeat (20) @(negedge clk);
                queue_tx(3, 8'h22);
            end
        join
        xfer_chk(3, 8'h7E, "m3_miso_b2");
        cs_high(3);
        chk("m3_dv_count", 32'(dv_cnt[3] - d), 32'd2);
        chk("m3_rx_byte", 32'(rx_byte[3]), 32'h7E);

        // Mode 1: nothing queued -> default byte
        d = dv_cnt[1];
`ifdef SPI_SLAVE_ERR_EN
        u = ur_cnt[1];
`endif
        exp_tx.push_back(8'hFF);
        cs_low(1);
`ifdef SPI_SLAVE_ERR_EN
        chk("m1_underrun_once", 32'(ur_cnt[1] - u), 32'd1);
`endif
        xfer_chk(1, 8'h55, "m1_miso_ff");
        cs_high(1);
        chk("m1_dv_count", 32'(dv_cnt[1] - d), 32'd1);
        chk("m1_rx_byte", 32'(rx_byte[1]), 32'h55);

        // Mode 2: aborted frame after 5 SCLK cycles, then a good frame
        d = dv_cnt[2];
`ifdef SPI_SLAVE_ERR_EN
        a = ab_cnt[2];
`endif
        cs_low(2);
        xfer_bits(2, 8'hAA, 5, junk);
        cs_high(2);
        chk("m2_abort_no_dv", 32'(dv_cnt[2] - d), 32'd0);
        chk("m2_abort_oe", 32'(oe[2]), 32'd0);
`ifdef SPI_SLAVE_ERR_EN
        chk("m2_frame_abort_once", 32'(ab_cnt[2] - a), 32'd1);
`endif
        exp_tx.push_back(8'hFF);
        d = dv_cnt[2];
        cs_low(2);
        xfer_chk(2, 8'hC3, "m2_miso_ff");
        cs_high(2);
        chk("m2_dv_count", 32'(dv_cnt[2] - d), 32'd1);
        chk("m2_rx_byte", 32'(rx_byte[2]), 32'hC3);

        // Mode 0: write while holding register full is dropped
        queue_tx(0, 8'h44);
        exp_tx.push_back(8'h44);
        chk("m0_ready_hold44", 32'(tx_ready[0]), 32'd0);
        queue_tx(0, 8'h99);
        chk("m0_ready_after_99", 32'(tx_ready[0]), 32'd0);
        cs_low(0);
        xfer_chk(0, 8'h12, "m0_miso_44");
        cs_high(0);
        exp_tx.push_back(8'hFF);
        cs_low(0);
        xfer_chk(0, 8'h34, "m0_miso_not_99");
        cs_high(0);

        // Mode 0: reset in mid-frame
        cs_low(0);
        queue_tx(0, 8'h5A);
        chk("m0_ready_before_rst", 32'(tx_ready[0]), 32'd0);
        xfer_bits(0, 8'hF0, 5, junk);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("m0_midrst_tx_ready", 32'(tx_ready[0]), 32'd1);
        chk("m0_midrst_rx_dv",    32'(rx_dv[0]),    32'd0);
        chk("m0_midrst_rx_byte",  32'(rx_byte[0]),  32'd0);
        chk("m0_midrst_miso",     32'(miso[0]),     32'd0);
        chk("m0_midrst_oe",       32'(oe[0]),       32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("m0_wait_fresh_fall_oe", 32'(oe[0]), 32'd0);
        cs_n[0] = 1'b1;
        repeat (10) @(negedge clk);
        queue_tx(0, 8'h6B);
        exp_tx.push_back(8'h6B);
        d = dv_cnt[0];
        cs_low(0);
        xfer_chk(0, 8'hE7, "m0_post_rst_miso");
        cs_high(0);
        chk("m0_post_rst_dv", 32'(dv_cnt[0] - d), 32'd1);
        chk("m0_post_rst_rx", 32'(rx_byte[0]), 32'hE7);

        chk("rx_scoreboard_drained", 32'(exp_rx.size()), 32'd0);
        chk("tx_scoreboard_drained", 32'(exp_tx.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
